// File: rtl/spi_regs_pkg.sv
// Shared constants, types and helpers for the SPI configuration register slave.
package spi_regs_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_LOW  = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_MID  = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_HIGH = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 8'h05;
    localparam logic [ADDR_W-1:0] ADDR_VOLUME    = 8'h06;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 8'h12;

    // Reset values
    localparam logic [DATA_W-1:0] RST_CONTROL   = 8'h00;
    localparam logic [DATA_W-1:0] RST_FREQ_LOW  = 8'h00;
    localparam logic [DATA_W-1:0] RST_FREQ_MID  = 8'h00;
    localparam logic [DATA_W-1:0] RST_FREQ_HIGH = 8'h00;
    localparam logic [DATA_W-1:0] RST_DUTY      = 8'h80;
    localparam logic [DATA_W-1:0] RST_VOLUME    = 8'hFF;
    localparam logic [DATA_W-1:0] RST_STATUS    = 8'h00;

    // Byte phase within a chip-select frame
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    // One pending register write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // True for addresses that map onto a writable register
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_CONTROL) ||
               ((addr >= ADDR_FREQ_LOW) && (addr <= ADDR_VOLUME));
    endfunction

endpackage

// File: rtl/spi_rx_registers_if.sv
// SPI pin bundle: the external master drives, the register slave listens.
interface spi_rx_registers_if;

    logic spi_sck;
    logic spi_mosi;
    logic spi_cs;

    modport master (
        output spi_sck,
        output spi_mosi,
        output spi_cs
    );

    modport slave (
        input spi_sck,
        input spi_mosi,
        input spi_cs
    );

endinterface

// File: rtl/spi_rx_registers_sync_edge.sv
// Brings the SPI pins into the clk domain and flags SCK rising / CS falling edges.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic mosi_i,
    input  logic cs_i,
    output logic sck_rise_c_o,
    output logic cs_fall_c_o,
    output logic cs_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    // Synchroniser chains. The CS chain resets low so that a CS held low across
    // reset never looks like a fresh falling edge; only a genuine high-to-low
    // transition observed after reset re-arms the slave.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge pulses from the synchronised levels
    always_comb begin
        sck_rise_c_o = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
        cs_fall_c_o  = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    end

    assign cs_o   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_o = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx_registers.sv
// Write-only SPI Mode 0 slave decoding [addr][data...] frames into config registers.
module spi_rx_registers
    import spi_regs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_rx_registers_if.slave   spi,
    input  logic                status_gate_active,
    input  logic                status_osc_running,
    output logic [DATA_W-1:0]   reg_control,
    output logic [DATA_W-1:0]   reg_freq_low,
    output logic [DATA_W-1:0]   reg_freq_mid,
    output logic [DATA_W-1:0]   reg_freq_high,
    output logic [DATA_W-1:0]   reg_duty,
    output logic [DATA_W-1:0]   reg_volume,
    output logic [DATA_W-1:0]   reg_status
);

    logic sck_rise;
    logic cs_fall;
    logic cs_sync;
    logic mosi_sync;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk          (clk),
        .rst          (rst),
        .sck_i        (spi.spi_sck),
        .mosi_i       (spi.spi_mosi),
        .cs_i         (spi.spi_cs),
        .sck_rise_c_o (sck_rise),
        .cs_fall_c_o  (cs_fall),
        .cs_o         (cs_sync),
        .mosi_o       (mosi_sync)
    );

    logic              armed_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [ADDR_W-1:0] addr_q;
    phase_e            phase_q;
    phase_e            phase_d;
    logic              wr_vld_q;
    wr_req_t           wr_q;

    logic              shift_en_c;
    logic              byte_done_c;
    logic [DATA_W-1:0] byte_c;
    logic              latch_addr_c;
    logic              write_req_c;

    logic [DATA_W-1:0] reg_control_q;
    logic [DATA_W-1:0] reg_freq_low_q;
    logic [DATA_W-1:0] reg_freq_mid_q;
    logic [DATA_W-1:0] reg_freq_high_q;
    logic [DATA_W-1:0] reg_duty_q;
    logic [DATA_W-1:0] reg_volume_q;
    logic [DATA_W-1:0] reg_status_q;

    // Bit capture qualifiers; the completed byte includes the bit arriving now
    always_comb begin
        shift_en_c  = armed_q & ~cs_sync & sck_rise;
        byte_c      = {shift_q[DATA_W-2:0], mosi_sync};
        byte_done_c = shift_en_c && (bit_cnt_q == CNT_W'(7));
    end

    // Shifter, bit counter and arming; after reset only a new CS fall re-arms
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            if (cs_fall) begin
                armed_q <= 1'b1;
            end
            if (cs_sync) begin
                bit_cnt_q <= '0;
            end else if (shift_en_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                shift_q   <= byte_c;
            end
        end
    end

    // Phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state: first byte is the address, CS high returns to address phase
    always_comb begin
        phase_d = phase_q;
        if (cs_sync) begin
            phase_d = PH_ADDR;
        end else if (byte_done_c && (phase_q == PH_ADDR)) begin
            phase_d = PH_DATA;
        end
    end

    // Phase outputs: latch the pointer or issue a data write on byte completion
    always_comb begin
        latch_addr_c = 1'b0;
        write_req_c  = 1'b0;
        if (byte_done_c) begin
            case (phase_q)
                PH_ADDR: latch_addr_c = 1'b1;
                PH_DATA: write_req_c  = 1'b1;
                default: ;
            endcase
        end
    end

    // Address pointer with auto-increment across a burst
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (latch_addr_c) begin
            addr_q <= byte_c;
        end else if (write_req_c) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // Write request stage; unmapped addresses are dropped here
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q <= 1'b0;
            wr_q     <= '0;
        end else begin
            wr_vld_q <= write_req_c && is_writable(addr_q);
            if (write_req_c) begin
                wr_q <= '{addr: addr_q, data: byte_c};
            end
        end
    end

    // Writable register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_control_q   <= RST_CONTROL;
            reg_freq_low_q  <= RST_FREQ_LOW;
            reg_freq_mid_q  <= RST_FREQ_MID;
            reg_freq_high_q <= RST_FREQ_HIGH;
            reg_duty_q      <= RST_DUTY;
            reg_volume_q    <= RST_VOLUME;
        end else if (wr_vld_q) begin
            case (wr_q.addr)
                ADDR_CONTROL:   reg_control_q   <= wr_q.data;
                ADDR_FREQ_LOW:  reg_freq_low_q  <= wr_q.data;
                ADDR_FREQ_MID:  reg_freq_mid_q  <= wr_q.data;
                ADDR_FREQ_HIGH: reg_freq_high_q <= wr_q.data;
                ADDR_DUTY:      reg_duty_q      <= wr_q.data;
                ADDR_VOLUME:    reg_volume_q    <= wr_q.data;
                default: ;
            endcase
        end
    end

    // Read-only status snapshot of the core flags
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_status_q <= RST_STATUS;
        end else begin
            reg_status_q <= {6'b0, status_osc_running, status_gate_active};
        end
    end

    assign reg_control   = reg_control_q;
    assign reg_freq_low  = reg_freq_low_q;
    assign reg_freq_mid  = reg_freq_mid_q;
    assign reg_freq_high = reg_freq_high_q;
    assign reg_duty      = reg_duty_q;
    assign reg_volume    = reg_volume_q;
    assign reg_status    = reg_status_q;

endmodule

// File: tb/tb_spi_rx_registers.sv
// Randomised self-checking bench for spi_rx_registers against a register-map model.
module tb_spi_rx_registers;

    logic       clk;
    logic       rst;
    logic       status_gate_active;
    logic       status_osc_running;
    logic [7:0] reg_control;
    logic [7:0] reg_freq_low;
    logic [7:0] reg_freq_mid;
    logic [7:0] reg_freq_high;
    logic [7:0] reg_duty;
    logic [7:0] reg_volume;
    logic [7:0] reg_status;

    int checks = 0;
    int errors = 0;

    // Model: index 0 control, 1..5 for addresses 0x02..0x06
    logic [7:0] exp_reg [0:5];
    logic [7:0] exp_status;

    spi_rx_registers_if spi_bus ();

    spi_rx_registers #(
        .SYNC_STAGES (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .spi                (spi_bus),
        .status_gate_active (status_gate_active),
        .status_osc_running (status_osc_running),
        .reg_control        (reg_control),
        .reg_freq_low       (reg_freq_low),
        .reg_freq_mid       (reg_freq_mid),
        .reg_freq_high      (reg_freq_high),
        .reg_duty           (reg_duty),
        .reg_volume         (reg_volume),
        .reg_status         (reg_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void mdl_reset();
        exp_reg[0] = 8'h00;
        exp_reg[1] = 8'h00;
        exp_reg[2] = 8'h00;
        exp_reg[3] = 8'h00;
        exp_reg[4] = 8'h80;
        exp_reg[5] = 8'hFF;
    endfunction

    function automatic void mdl_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h00) exp_reg[0] = d;
        else if (a >= 8'h02 && a <= 8'h06) exp_reg[a - 8'h01] = d;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".control"}, 32'(reg_control),   32'(exp_reg[0]));
        check({tag, ".flow"},    32'(reg_freq_low),  32'(exp_reg[1]));
        check({tag, ".fmid"},    32'(reg_freq_mid),  32'(exp_reg[2]));
        check({tag, ".fhigh"},   32'(reg_freq_high), 32'(exp_reg[3]));
        check({tag, ".duty"},    32'(reg_duty),      32'(exp_reg[4]));
        check({tag, ".volume"},  32'(reg_volume),    32'(exp_reg[5]));
        check({tag, ".status"},  32'(reg_status),    32'(exp_status));
    endtask

    task automatic set_status(input logic gate, input logic osc);
        status_gate_active = gate;
        status_osc_running = osc;
        exp_status = {6'b0, osc, gate};
    endtask

    // Shift out the top nbits of b, MSB first, 8 clk per SCK period
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_bus.spi_mosi = b[i];
            tick(4);
            spi_bus.spi_sck = 1'b1;
            tick(4);
            spi_bus.spi_sck = 1'b0;
        end
    endtask

    // Full CS frame of whole bytes, optionally followed by a truncated byte
    task automatic frame(input logic [7:0] q[$], input int pbits, input logic [7:0] pdata);
        logic [7:0] a;
        spi_bus.spi_cs = 1'b0;
        tick(4);
        foreach (q[i]) send_bits(q[i], 8);
        if (pbits > 0) send_bits(pdata, pbits);
        tick(4);
        spi_bus.spi_cs = 1'b1;
        tick(8);
        if (q.size() > 0) begin
            a = q[0];
            for (int i = 1; i < q.size(); i++) begin
                mdl_write(a, q[i]);
                a = a + 8'h01;
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] vols [0:4];
        int         r;
        logic [7:0] addr;
        int         pb;

        rst = 1'b1;
        spi_bus.spi_cs   = 1'b1;
        spi_bus.spi_sck  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        set_status(1'b0, 1'b0);
        mdl_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        check_all("reset");

        // Single write with exact-latency probe on the last data bit
        spi_bus.spi_cs = 1'b0;
        tick(4);
        send_bits(8'h00, 8);
        send_bits(8'h1D, 7);
        spi_bus.spi_mosi = 1'b1;
        tick(4);
        spi_bus.spi_sck = 1'b1;
        tick(3);
        check("lat_before", 32'(reg_control), 32'h00);
        tick(1);
        check("lat_after", 32'(reg_control), 32'h1D);
        tick(3);
        spi_bus.spi_sck = 1'b0;
        tick(4);
        spi_bus.spi_cs = 1'b1;
        tick(8);
        mdl_write(8'h00, 8'h1D);
        check_all("single");

        // Frequency word across three frames, then duty
        q = '{8'h02, 8'h00}; frame(q, 0, 8'h00);
        q = '{8'h03, 8'h40}; frame(q, 0, 8'h00);
        q = '{8'h04, 8'h02}; frame(q, 0, 8'h00);
        check("freq_word", 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'h024000);
        q = '{8'h05, 8'h40}; frame(q, 0, 8'h00);
        check_all("duty");

        vols = '{8'h80, 8'h00, 8'h40, 8'hC0, 8'hFF};
        foreach (vols[i]) begin
            q = '{8'h06, vols[i]};
            frame(q, 0, 8'h00);
            check("volume_seq", 32'(reg_volume), 32'(vols[i]));
        end

        // Burst across the frequency registers
        q = '{8'h02, 8'hAA, 8'hBB, 8'hCC}; frame(q, 0, 8'h00);
        check("burst_freq", 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'hCCBBAA);
        check_all("burst");

        // Status follows inputs, ignores SPI writes
        set_status(1'b1, 1'b1);
        tick(2);
        check("status_11", 32'(reg_status), 32'h03);
        q = '{8'h12, 8'hFF}; frame(q, 0, 8'h00);
        check_all("status_write");
        set_status(1'b1, 1'b0);
        tick(2);
        check("status_10", 32'(reg_status), 32'h01);

        // Unmapped address and a truncated data byte
        q = '{8'h07, 8'h42}; frame(q, 0, 8'h00);
        check_all("invalid_addr");
        q = '{8'h06}; frame(q, 4, 8'h12);
        check_all("partial");
        q = '{8'h06, 8'h12}; frame(q, 0, 8'h00);
        check_all("after_partial");

        // Randomised frames
        for (int n = 0; n < 25; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 6) addr = 8'(r);
            else if (r == 7) addr = 8'h07;
            else if (r == 8) addr = 8'h12;
            else addr = 8'($urandom);
            q = '{addr};
            r = int'($urandom_range(0, 3));
            for (int k = 0; k < r; k++) q.push_back(8'($urandom));
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            set_status(1'($urandom), 1'($urandom));
            frame(q, pb, 8'($urandom));
            check_all("random");
        end

        // Reset in the middle of a frame; CS stays low afterwards
        q = '{8'h00, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        frame(q, 0, 8'h00);
        check_all("pre_rst");
        spi_bus.spi_cs = 1'b0;
        tick(4);
        send_bits(8'h06, 8);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mdl_reset();
        tick(2);
        check_all("mid_rst");
        send_bits(8'h55, 8);
        send_bits(8'h66, 8);
        tick(4);
        spi_bus.spi_cs = 1'b1;
        tick(8);
        check_all("no_cs_fall");
        q = '{8'h06, 8'h33}; frame(q, 0, 8'h00);
        check_all("resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
